jk_ff_checker: RTL and testbench
================================

Name: jk_ff_checker

Overview:
- Synthesizable observer for the far end of the JK flip-flop interface.
- Consumes the same j/k stimulus a JK flip-flop receives, reads back its q/q_bar, and checks every clock edge against the JK characteristic equation.
- Flags mismatches and keeps event counters, so hardware and simulation benches self-check instead of relying on printed traces.
- Sits beside any jk_ff instance on the same clk and reset.

Parameters:
- CNT_W, 8: width of all counters; counters saturate at 2^CNT_W-1.
- STOP_ON_ERR, 0: 0 = keep checking after an error; 1 = freeze in HALT on the first error.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- en  input  1  checking enable.
- j  input  1  J input as driven to the observed flip-flop.
- k  input  1  K input as driven to the observed flip-flop.
- q  input  1  observed flip-flop output.
- q_bar  input  1  observed complement output.
- err_pulse  output  1  one-cycle error strobe.
- err_code  output  2  bit0 = q mismatch, bit1 = complement violation; valid while err_pulse=1.
- err_sticky  output  1  latched error flag.
- err_count  output  CNT_W  number of erroneous edges.
- check_count  output  CNT_W  number of compares performed.
- toggle_count  output  CNT_W  number of checked J=K=1 edges.
- state  output  2  FSM state: 00 IDLE, 01 CHECK, 10 HALT.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - exp_q=0, exp_valid=0.
  - All outputs 0.
- Sampling: on each rising edge, j, k, q and q_bar are sampled as their pre-edge values.
  - Sampled q is the flip-flop state produced by the previous edge.
- Model:
  - jk_next(s,j,k) gives s for 00, 1 for 10, 0 for 01, and ~s for 11.
  - In IDLE and CHECK, every edge loads exp_q <= jk_next(q_sampled, j, k) and sets exp_valid=1.
  - The model resyncs to the observed q every cycle. Each faulty transition is therefore reported exactly once, with no error cascade.
- Compare: performed at an edge only when state=CHECK and exp_valid=1.
  - q_mis = (q != exp_q).
  - comp_mis = (q_bar != ~q).
- FSM:
  - IDLE: en=1 at an edge -> CHECK. No compare on that edge.
  - CHECK: en=0 -> IDLE, but the compare on that edge is still performed. If any mismatch and STOP_ON_ERR=1 -> HALT. Otherwise stay in CHECK.
  - HALT: terminal. No compares, no counter or model updates, outputs hold. Exits only via reset.
- Outputs (registered, one cycle latency from the sampling edge):
  - err_pulse=1 and err_code={comp_mis,q_mis} for exactly one cycle after an edge with any mismatch. Otherwise err_pulse=0 and err_code=00.
  - err_sticky is set together with the first err_pulse and cleared only by reset.
  - err_count increments by 1 per erroneous edge, even when both bits are set. It saturates and does not wrap.
  - check_count increments per compare performed. It saturates.
  - toggle_count increments per compare performed with j=k=1 sampled. It saturates.
- Boundaries:
  - First edge after reset release: exp_valid=0, so no compare even if en=1.
  - en toggled low and back high: counters hold their values. Model tracking continues in IDLE, so no resync gap.
  - Reset asserted mid-CHECK or in HALT: immediate return to the reset values.

Test Plan:
- Reset held low for 2 cycles with random j/k/q -> state=00, all counters 0, err_sticky=0.
- Reset release, en=1, correct jk_ff driven with j/k sequence 00,10,01,11,11,00 -> err_count=0, err_sticky=0, toggle_count=2, check_count equals the number of edges after the first.
- q forced to 0 after a 10 (set) edge -> err_pulse high for exactly 1 cycle with err_code=01, err_count=1, err_sticky=1. Checking continues, and later clean edges give no pulses.
- q_bar forced equal to q for one edge -> err_code=10. q and q_bar both wrong on one edge -> err_code=11 and err_count +1 only.
- STOP_ON_ERR=1, inject one q error -> state=10 next cycle, counters frozen despite further errors. Pull reset low mid-HALT -> all state cleared, state=00.
- CNT_W=2, inject 5 separate q errors -> err_count saturates at 3. en deasserted -> state=00 and counters hold.

Source files
------------

// File: rtl/jk_ff_checker.sv
// Observer for a JK flip-flop: predicts each edge's q from the previous sampled
// q and j/k, compares, and keeps saturating error/compare/toggle counters.
module jk_ff_checker #(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    input  logic             q_bar,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] toggle_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        HALT  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             expq_q, expq_d;
    logic             exp_valid_q, exp_valid_d;
    logic             err_pulse_q, err_pulse_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] check_count_q, check_count_d;
    logic [CNT_W-1:0] toggle_count_q, toggle_count_d;

    logic do_cmp, q_mis, comp_mis, any_mis, jk_next;

    always_comb begin
        unique case ({j, k})
            2'b00:   jk_next = q;
            2'b10:   jk_next = 1'b1;
            2'b01:   jk_next = 1'b0;
            default: jk_next = ~q;
        endcase
    end

    assign do_cmp   = (state_q == CHECK) && exp_valid_q;
    assign q_mis    = do_cmp && (q != expq_q);
    assign comp_mis = do_cmp && (q_bar == q);
    assign any_mis  = q_mis || comp_mis;

    always_comb begin
        state_d        = state_q;
        expq_d         = expq_q;
        exp_valid_d    = exp_valid_q;
        err_pulse_d    = 1'b0;
        err_code_d     = 2'b00;
        err_sticky_d   = err_sticky_q;
        err_count_d    = err_count_q;
        check_count_d  = check_count_q;
        toggle_count_d = toggle_count_q;

        // HALT freezes model and counters; the strobe still drops after one cycle.
        if (state_q != HALT) begin
            expq_d      = jk_next;
            exp_valid_d = 1'b1;
            err_pulse_d = any_mis;
            err_code_d  = {comp_mis, q_mis};
            if (do_cmp) begin
                if (check_count_q != CNT_MAX) check_count_d = check_count_q + CNT_ONE;
                if (j && k && toggle_count_q != CNT_MAX) toggle_count_d = toggle_count_q + CNT_ONE;
            end
            if (any_mis) begin
                err_sticky_d = 1'b1;
                if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_ONE;
            end
        end

        unique case (state_q)
            IDLE:    if (en) state_d = CHECK;
            CHECK: begin
                if (any_mis && STOP_ON_ERR) state_d = HALT;
                else if (!en)               state_d = IDLE;
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            expq_q         <= 1'b0;
            exp_valid_q    <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_code_q     <= 2'b00;
            err_sticky_q   <= 1'b0;
            err_count_q    <= '0;
            check_count_q  <= '0;
            toggle_count_q <= '0;
        end else begin
            state_q        <= state_d;
            expq_q         <= expq_d;
            exp_valid_q    <= exp_valid_d;
            err_pulse_q    <= err_pulse_d;
            err_code_q     <= err_code_d;
            err_sticky_q   <= err_sticky_d;
            err_count_q    <= err_count_d;
            check_count_q  <= check_count_d;
            toggle_count_q <= toggle_count_d;
        end
    end

    assign err_pulse    = err_pulse_q;
    assign err_code     = err_code_q;
    assign err_sticky   = err_sticky_q;
    assign err_count    = err_count_q;
    assign check_count  = check_count_q;
    assign toggle_count = toggle_count_q;
    assign state        = state_q;

endmodule

// File: tb/tb_jk_ff_checker.sv
// Bench for jk_ff_checker: three instances (default, stop-on-error, 2-bit
// counters) watch one emulated JK flop with injectable faults.
module tb_jk_ff_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, en, j, k, ff, qb_fault;
    logic q, q_bar;
    assign q     = ff;
    assign q_bar = qb_fault ? ff : ~ff;

    logic       o_pulse[3];
    logic [1:0] o_code[3];
    logic       o_sticky[3];
    logic [7:0] o_err[3], o_chk[3], o_tog[3];
    logic [1:0] o_state[3];
    logic [1:0] e2, c2, t2;
    assign o_err[2] = {6'b0, e2};
    assign o_chk[2] = {6'b0, c2};
    assign o_tog[2] = {6'b0, t2};

    jk_ff_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .j(j), .k(k), .q(q), .q_bar(q_bar),
        .err_pulse(o_pulse[0]), .err_code(o_code[0]), .err_sticky(o_sticky[0]),
        .err_count(o_err[0]), .check_count(o_chk[0]), .toggle_count(o_tog[0]),
        .state(o_state[0]));

    jk_ff_checker #(.CNT_W(8), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .j(j), .k(k), .q(q), .q_bar(q_bar),
        .err_pulse(o_pulse[1]), .err_code(o_code[1]), .err_sticky(o_sticky[1]),
        .err_count(o_err[1]), .check_count(o_chk[1]), .toggle_count(o_tog[1]),
        .state(o_state[1]));

    jk_ff_checker #(.CNT_W(2), .STOP_ON_ERR(1'b0)) dut2 (
        .clk(clk), .reset(reset), .en(en), .j(j), .k(k), .q(q), .q_bar(q_bar),
        .err_pulse(o_pulse[2]), .err_code(o_code[2]), .err_sticky(o_sticky[2]),
        .err_count(e2), .check_count(c2), .toggle_count(t2),
        .state(o_state[2]));

    // Reference model: mode 0 idle, 1 checking, 2 halted.
    int m_cw[3]   = '{8, 8, 2};
    bit m_stop[3] = '{1'b0, 1'b1, 1'b0};
    int m_mode[3], m_code[3], m_err[3], m_chk[3], m_tog[3];
    bit m_have[3], m_exp[3], m_pulse[3], m_sticky[3];

    int pass_cnt = 0;
    int total_cnt = 0;

    function automatic int sat_inc(int v, int w);
        return (v >= (1 << w) - 1) ? v : v + 1;
    endfunction

    task automatic model_clear(int i);
        m_mode[i] = 0; m_have[i] = 0; m_exp[i] = 0; m_pulse[i] = 0;
        m_code[i] = 0; m_sticky[i] = 0; m_err[i] = 0; m_chk[i] = 0; m_tog[i] = 0;
    endtask

    task automatic model_edge(int i);
        bit cmp, qm, cm;
        if (m_mode[i] == 2) begin
            m_pulse[i] = 0;
            m_code[i]  = 0;
            return;
        end
        cmp = (m_mode[i] == 1) && m_have[i];
        qm  = cmp && (q != m_exp[i]);
        cm  = cmp && (q_bar == q);
        m_pulse[i] = qm || cm;
        m_code[i]  = 2 * int'(cm) + int'(qm);
        if (cmp) begin
            m_chk[i] = sat_inc(m_chk[i], m_cw[i]);
            if (j && k) m_tog[i] = sat_inc(m_tog[i], m_cw[i]);
        end
        if (qm || cm) begin
            m_err[i]    = sat_inc(m_err[i], m_cw[i]);
            m_sticky[i] = 1;
        end
        if (j && k)  m_exp[i] = !q;
        else if (j)  m_exp[i] = 1;
        else if (k)  m_exp[i] = 0;
        else         m_exp[i] = q;
        m_have[i] = 1;
        if (m_mode[i] == 0)               m_mode[i] = en ? 1 : 0;
        else if ((qm || cm) && m_stop[i]) m_mode[i] = 2;
        else if (!en)                     m_mode[i] = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) for (int i = 0; i < 3; i++) model_clear(i);
        else        for (int i = 0; i < 3; i++) model_edge(i);
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Every-cycle comparison against the model, well away from both edges.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("cyc dut%0d err_pulse", i), int'(o_pulse[i]), int'(m_pulse[i]));
                check($sformatf("cyc dut%0d err_code", i), int'(o_code[i]), m_code[i]);
                check($sformatf("cyc dut%0d err_sticky", i), int'(o_sticky[i]), int'(m_sticky[i]));
                check($sformatf("cyc dut%0d err_count", i), int'(o_err[i]), m_err[i]);
                check($sformatf("cyc dut%0d check_count", i), int'(o_chk[i]), m_chk[i]);
                check($sformatf("cyc dut%0d toggle_count", i), int'(o_tog[i]), m_tog[i]);
                check($sformatf("cyc dut%0d state", i), int'(o_state[i]), m_mode[i]);
            end
        end
    end

    // One clock edge: drive j/k at negedge, then the emulated flop transitions
    // just after posedge (inverted when flt=1).
    task automatic step(input logic jv, input logic kv, input bit flt, input bit qbf);
        logic nx;
        @(negedge clk);
        j = jv; k = kv; qb_fault = qbf;
        @(posedge clk);
        #1;
        if (jv && kv) nx = ~ff;
        else if (jv)  nx = 1'b1;
        else if (kv)  nx = 1'b0;
        else          nx = ff;
        ff = flt ? ~nx : nx;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; j = 1'b0; k = 1'b0; ff = 1'b0; qb_fault = 1'b0;
        repeat (2) begin
            @(negedge clk);
            j = 1'($urandom_range(0, 1)); k = 1'($urandom_range(0, 1)); ff = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset dut%0d state", i), int'(o_state[i]), 0);
            check($sformatf("reset dut%0d err_count", i), int'(o_err[i]), 0);
            check($sformatf("reset dut%0d check_count", i), int'(o_chk[i]), 0);
            check($sformatf("reset dut%0d sticky", i), int'(o_sticky[i]), 0);
        end

        // Clean run: first edge arms the model, the next five are compared.
        reset = 1'b1; en = 1'b1; ff = 1'b0;
        step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 1, 0, 0);
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(0, 0, 0, 0);
        check("clean model check_count", m_chk[0], 5);
        check("clean check_count", int'(o_chk[0]), 5);
        check("clean toggle_count", int'(o_tog[0]), 2);
        check("clean err_count", int'(o_err[0]), 0);
        check("clean sticky", int'(o_sticky[0]), 0);
        check("clean cnt2 check_count sat", int'(o_chk[2]), 3);
        check("clean cnt2 toggle_count", int'(o_tog[2]), 2);

        // Faulty set transition: q stays 0 after a 10 edge.
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        check("qerr pulse", int'(o_pulse[0]), 1);
        check("qerr code", int'(o_code[0]), 1);
        check("qerr err_count", int'(o_err[0]), 1);
        check("qerr sticky", int'(o_sticky[0]), 1);
        check("halt state", int'(o_state[1]), 2);
        check("halt check_count", int'(o_chk[1]), 7);
        step(0, 0, 0, 0);
        check("after qerr pulse", int'(o_pulse[0]), 0);
        check("after qerr code", int'(o_code[0]), 0);
        check("after qerr err_count", int'(o_err[0]), 1);
        check("halt pulse dropped", int'(o_pulse[1]), 0);
        step(1, 0, 0, 0); step(0, 1, 0, 0);

        // Complement violation, then q and q_bar wrong on the same edge.
        step(0, 0, 0, 1);
        check("qbar code", int'(o_code[0]), 2);
        check("qbar err_count", int'(o_err[0]), 2);
        check("halt err_count frozen", int'(o_err[1]), 1);
        step(1, 1, 1, 0);
        step(0, 0, 0, 1);
        check("both code", int'(o_code[0]), 3);
        check("both err_count", int'(o_err[0]), 3);
        check("cnt2 err_count", int'(o_err[2]), 3);

        step(1, 0, 1, 0); step(0, 0, 0, 0);
        step(1, 0, 1, 0); step(0, 0, 0, 0);
        check("five errs err_count", int'(o_err[0]), 5);
        check("cnt2 err_count sat", int'(o_err[2]), 3);
        check("halt check_count frozen", int'(o_chk[1]), 7);
        check("halt state held", int'(o_state[1]), 2);

        // en low: last compare still happens, then counters hold in IDLE.
        en = 1'b0;
        step(1, 1, 0, 0);
        check("en low state", int'(o_state[0]), 0);
        check("en low check_count", int'(o_chk[0]), 18);
        check("en low toggle_count", int'(o_tog[0]), 4);
        step(0, 1, 0, 0);
        check("idle check_count hold", int'(o_chk[0]), 18);
        en = 1'b1;
        step(1, 0, 0, 0);
        check("reenable state", int'(o_state[0]), 1);
        check("reenable check_count", int'(o_chk[0]), 18);
        step(0, 0, 0, 0);
        check("resume check_count", int'(o_chk[0]), 19);
        check("resume no pulse", int'(o_pulse[0]), 0);
        check("resume err_count", int'(o_err[0]), 5);

        // Asynchronous reset in the middle of a cycle, including the halted instance.
        reset = 1'b0;
        #1;
        check("async rst halt state", int'(o_state[1]), 0);
        check("async rst halt check_count", int'(o_chk[1]), 0);
        check("async rst err_count", int'(o_err[0]), 0);
        check("async rst sticky", int'(o_sticky[0]), 0);
        @(posedge clk); #1;
        reset = 1'b1; ff = 1'b1;
        step(0, 0, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0);
        check("post rst check_count", int'(o_chk[1]), 2);
        check("post rst toggle_count", int'(o_tog[1]), 1);

        @(posedge clk); #3;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
